// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single memory_top bus port between two masters (0 = CPU, 1 = SD/DMA).
//   Each master owns a one-deep pending slot that captures its single-cycle request.
//   Pending slots are granted round-robin, one transaction at a time. The memory
//   response is routed back to the granted master. A non-responding slave is aborted
//   after TIMEOUT_CYCLES wait cycles with TIMEOUT_DATA as the read data.
//
// Ports
//   i_clk, i_reset                     clock, synchronous active-high reset
//   i_mN_data/address/bhw/write_notread master N request fields (N = 0,1)
//   i_mN_DV                            master N request strobe (one-cycle pulse)
//   o_mN_data, o_mN_DV, o_mN_timeout   response data / strobe / timeout flag to master N
//   o_mem_data/address/bhw/write_notread, o_mem_DV   request to memory_top
//   i_mem_data, i_mem_DV               response from memory_top
//   o_busy                             high while a transaction is in progress
//   o_protocol_err                     sticky: a request arrived while that master was still busy
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_m0_data,
  input  logic [31:0] i_m0_address,
  input  logic        i_m0_DV,
  input  logic [2:0]  i_m0_bhw,
  input  logic        i_m0_write_notread,
  input  logic [31:0] i_m1_data,
  input  logic [31:0] i_m1_address,
  input  logic        i_m1_DV,
  input  logic [2:0]  i_m1_bhw,
  input  logic        i_m1_write_notread,
  output logic [31:0] o_m0_data,
  output logic        o_m0_DV,
  output logic        o_m0_timeout,
  output logic [31:0] o_m1_data,
  output logic        o_m1_DV,
  output logic        o_m1_timeout,
  output logic [31:0] o_mem_data,
  output logic [31:0] o_mem_address,
  output logic        o_mem_DV,
  output logic [2:0]  o_mem_bhw,
  output logic        o_mem_write_notread,
  input  logic [31:0] i_mem_data,
  input  logic        i_mem_DV,
  output logic        o_busy,
  output logic        o_protocol_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic        grant_reg, grant_next;   // master owning the current transaction
  logic        last_reg, last_next;     // master granted most recently
  logic [31:0] cnt_reg, cnt_next;       // WAIT-cycle counter
  logic [31:0] mem_data_reg, mem_data_next;
  logic [31:0] mem_addr_reg, mem_addr_next;
  logic [2:0]  mem_bhw_reg, mem_bhw_next;
  logic        mem_wnr_reg, mem_wnr_next;
  logic        mem_dv_reg, mem_dv_next;
  logic [31:0] resp_data_reg [2];
  logic [31:0] resp_data_next [2];
  logic [1:0]  resp_dv_reg, resp_dv_next;
  logic [1:0]  resp_to_reg, resp_to_next;
  logic        perr_reg, perr_next;
  logic        pick;

  // Fan the two master ports into arrays so the slot logic can be generated.
  logic [1:0]  req_dv, req_wnr;
  logic [31:0] req_data [2];
  logic [31:0] req_addr [2];
  logic [2:0]  req_bhw [2];

  assign req_dv      = {i_m1_DV, i_m0_DV};
  assign req_wnr     = {i_m1_write_notread, i_m0_write_notread};
  assign req_data[0] = i_m0_data;
  assign req_data[1] = i_m1_data;
  assign req_addr[0] = i_m0_address;
  assign req_addr[1] = i_m1_address;
  assign req_bhw[0]  = i_m0_bhw;
  assign req_bhw[1]  = i_m1_bhw;

  logic [1:0]  slot_full, slot_take, slot_drop, slot_wnr;
  logic [31:0] slot_data [2];
  logic [31:0] slot_addr [2];
  logic [2:0]  slot_bhw [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    logic        full_reg;
    logic        wnr_reg;
    logic [31:0] data_reg;
    logic [31:0] addr_reg;
    logic [2:0]  bhw_reg;
    logic        in_flight;

    // A master is in flight from its grant edge until its response edge.
    assign in_flight     = (state_reg != IDLE) && (grant_reg == 1'(gi));
    assign slot_drop[gi] = req_dv[gi] && (full_reg || in_flight);

    // Capture only into an empty slot of an idle master; a slot being granted this
    // edge is still full, so a request arriving on that edge is dropped.
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        full_reg <= 1'b0;
        wnr_reg  <= 1'b0;
        data_reg <= '0;
        addr_reg <= '0;
        bhw_reg  <= '0;
      end else if (req_dv[gi] && !full_reg && !in_flight) begin
        full_reg <= 1'b1;
        wnr_reg  <= req_wnr[gi];
        data_reg <= req_data[gi];
        addr_reg <= req_addr[gi];
        bhw_reg  <= req_bhw[gi];
      end else if (slot_take[gi]) begin
        full_reg <= 1'b0;
      end
    end

    assign slot_full[gi] = full_reg;
    assign slot_wnr[gi]  = wnr_reg;
    assign slot_data[gi] = data_reg;
    assign slot_addr[gi] = addr_reg;
    assign slot_bhw[gi]  = bhw_reg;
  end

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    last_next      = last_reg;
    cnt_next       = cnt_reg;
    mem_data_next  = mem_data_reg;
    mem_addr_next  = mem_addr_reg;
    mem_bhw_next   = mem_bhw_reg;
    mem_wnr_next   = mem_wnr_reg;
    mem_dv_next    = 1'b0;
    resp_data_next = resp_data_reg;
    resp_dv_next   = '0;
    resp_to_next   = '0;
    slot_take      = '0;
    perr_next      = perr_reg | (|slot_drop);
    pick           = 1'b0;

    case (state_reg)
      IDLE: begin
        // Stray or late memory responses are ignored here.
        if (|slot_full) begin
          // Tie goes to the master that was not granted last.
          if (&slot_full) pick = ~last_reg;
          else            pick = slot_full[1];
          grant_next      = pick;
          last_next       = pick;
          slot_take[pick] = 1'b1;
          mem_data_next   = slot_data[pick];
          mem_addr_next   = slot_addr[pick];
          mem_bhw_next    = slot_bhw[pick];
          mem_wnr_next    = slot_wnr[pick];
          mem_dv_next     = 1'b1;
          state_next      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next = '0;
        if (i_mem_DV) begin
          resp_dv_next[grant_reg]   = 1'b1;
          resp_data_next[grant_reg] = i_mem_data;
          state_next                = IDLE;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        // A real response on the timeout cycle takes precedence over the abort.
        if (i_mem_DV) begin
          resp_dv_next[grant_reg]   = 1'b1;
          resp_data_next[grant_reg] = i_mem_data;
          state_next                = IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_reg == TIMEOUT_CYCLES)) begin
          resp_dv_next[grant_reg]   = 1'b1;
          resp_to_next[grant_reg]   = 1'b1;
          resp_data_next[grant_reg] = TIMEOUT_DATA;
          state_next                = IDLE;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg        <= IDLE;
      grant_reg        <= 1'b0;
      last_reg         <= 1'b1;   // master 0 wins the first tie
      cnt_reg          <= '0;
      mem_data_reg     <= '0;
      mem_addr_reg     <= '0;
      mem_bhw_reg      <= '0;
      mem_wnr_reg      <= 1'b0;
      mem_dv_reg       <= 1'b0;
      resp_data_reg[0] <= '0;
      resp_data_reg[1] <= '0;
      resp_dv_reg      <= '0;
      resp_to_reg      <= '0;
      perr_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      grant_reg        <= grant_next;
      last_reg         <= last_next;
      cnt_reg          <= cnt_next;
      mem_data_reg     <= mem_data_next;
      mem_addr_reg     <= mem_addr_next;
      mem_bhw_reg      <= mem_bhw_next;
      mem_wnr_reg      <= mem_wnr_next;
      mem_dv_reg       <= mem_dv_next;
      resp_data_reg[0] <= resp_data_next[0];
      resp_data_reg[1] <= resp_data_next[1];
      resp_dv_reg      <= resp_dv_next;
      resp_to_reg      <= resp_to_next;
      perr_reg         <= perr_next;
    end
  end

  assign o_m0_data           = resp_data_reg[0];
  assign o_m1_data           = resp_data_reg[1];
  assign o_m0_DV             = resp_dv_reg[0];
  assign o_m1_DV             = resp_dv_reg[1];
  assign o_m0_timeout        = resp_to_reg[0];
  assign o_m1_timeout        = resp_to_reg[1];
  assign o_mem_data          = mem_data_reg;
  assign o_mem_address       = mem_addr_reg;
  assign o_mem_bhw           = mem_bhw_reg;
  assign o_mem_write_notread = mem_wnr_reg;
  assign o_mem_DV            = mem_dv_reg;
  assign o_busy              = (state_reg != IDLE);
  assign o_protocol_err      = perr_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a timestamp-based transaction model of the arbiter.
module tb_mem_bus_arbiter;
  localparam int          T     = 16;
  localparam logic [31:0] TDATA = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_m0_data, i_m0_address, i_m1_data, i_m1_address;
  logic        i_m0_DV, i_m1_DV, i_m0_write_notread, i_m1_write_notread;
  logic [2:0]  i_m0_bhw, i_m1_bhw;
  logic [31:0] o_m0_data, o_m1_data, o_mem_data, o_mem_address, i_mem_data;
  logic        o_m0_DV, o_m1_DV, o_m0_timeout, o_m1_timeout;
  logic        o_mem_DV, o_mem_write_notread, i_mem_DV, o_busy, o_protocol_err;
  logic [2:0]  o_mem_bhw;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(T), .TIMEOUT_DATA(TDATA)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_m0_data(i_m0_data), .i_m0_address(i_m0_address), .i_m0_DV(i_m0_DV),
    .i_m0_bhw(i_m0_bhw), .i_m0_write_notread(i_m0_write_notread),
    .i_m1_data(i_m1_data), .i_m1_address(i_m1_address), .i_m1_DV(i_m1_DV),
    .i_m1_bhw(i_m1_bhw), .i_m1_write_notread(i_m1_write_notread),
    .o_m0_data(o_m0_data), .o_m0_DV(o_m0_DV), .o_m0_timeout(o_m0_timeout),
    .o_m1_data(o_m1_data), .o_m1_DV(o_m1_DV), .o_m1_timeout(o_m1_timeout),
    .o_mem_data(o_mem_data), .o_mem_address(o_mem_address), .o_mem_DV(o_mem_DV),
    .o_mem_bhw(o_mem_bhw), .o_mem_write_notread(o_mem_write_notread),
    .i_mem_data(i_mem_data), .i_mem_DV(i_mem_DV),
    .o_busy(o_busy), .o_protocol_err(o_protocol_err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- reference model (transaction timestamps) ----------------
  bit          s_full [2];
  logic [31:0] s_data [2];
  logic [31:0] s_addr [2];
  logic [2:0]  s_bhw [2];
  bit          s_wnr [2];
  bit          last;                 // master granted most recently
  bit          have_txn;
  int          g_cyc, end_cyc, r_cyc; // grant cycle, last busy cycle, planned response cycle
  bit          g_who, g_to;
  logic [31:0] r_data;
  logic [31:0] e_mdata, e_maddr;
  logic [2:0]  e_mbhw;
  bit          e_mwnr;
  logic [31:0] e_rdata [2];
  bit          perr;
  int          delay_q [$];          // -1 = memory never answers
  logic [31:0] rdata_q [$];
  bit          stray_en, force_mem;

  // event log of observed DUT activity
  int          mem_cnt, m0_cnt, m1_cnt, to0_cnt;
  int          first_mem, first_m0;
  logic [31:0] addr_q [$];
  logic [31:0] seen_data;
  logic [2:0]  seen_bhw;
  bit          seen_wnr;

  function automatic bit nonidle(int c);
    return have_txn && (c > g_cyc) && (c <= end_cyc);
  endfunction

  function automatic bit legal(int n);
    return !s_full[n] && !(nonidle(cyc) && (g_who == 1'(n)));
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      s_full[n] = 0; e_rdata[n] = '0;
    end
    last = 1; have_txn = 0; perr = 0;
    e_mdata = '0; e_maddr = '0; e_mbhw = '0; e_mwnr = 0;
    delay_q.delete(); rdata_q.delete();
  endtask

  task automatic clr_ev();
    mem_cnt = 0; m0_cnt = 0; m1_cnt = 0; to0_cnt = 0;
    first_mem = -1; first_m0 = -1;
    addr_q.delete();
  endtask

  task automatic cap(input int n, input bit dv, input logic [31:0] d, input logic [31:0] a,
                     input logic [2:0] b, input bit w, input bit infl);
    if (dv) begin
      if (s_full[n] || infl) perr = 1;
      else begin
        s_full[n] = 1; s_data[n] = d; s_addr[n] = a; s_bhw[n] = b; s_wnr[n] = w;
      end
    end
  endtask

  task automatic set_req(input int n, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] b, input bit w);
    if (n == 0) begin
      i_m0_DV = 1; i_m0_address = a; i_m0_data = d; i_m0_bhw = b; i_m0_write_notread = w;
    end else begin
      i_m1_DV = 1; i_m1_address = a; i_m1_data = d; i_m1_bhw = b; i_m1_write_notread = w;
    end
  endtask

  // One clock cycle: drive memory side, compare outputs, advance the model.
  task automatic tick();
    bit idle_now, pick, grant_now, dlv;
    bit infl [2];
    int d, r;
    if (force_mem) begin
      i_mem_DV = 1; i_mem_data = $urandom;
    end else if (nonidle(cyc) && cyc == r_cyc) begin
      i_mem_DV = 1; i_mem_data = r_data;
    end else if (stray_en && !nonidle(cyc) && $urandom_range(0, 9) == 0) begin
      i_mem_DV = 1; i_mem_data = $urandom;
    end else begin
      i_mem_DV = 0; i_mem_data = $urandom;
    end

    @(negedge clk);
    dlv = have_txn && (cyc == end_cyc + 1);
    check("mem_dv",   32'(o_mem_DV), 32'(have_txn && cyc == g_cyc + 1));
    check("mem_data", o_mem_data, e_mdata);
    check("mem_addr", o_mem_address, e_maddr);
    check("mem_bhw",  32'(o_mem_bhw), 32'(e_mbhw));
    check("mem_wnr",  32'(o_mem_write_notread), 32'(e_mwnr));
    check("busy",     32'(o_busy), 32'(nonidle(cyc)));
    check("m0_dv",    32'(o_m0_DV), 32'(dlv && g_who == 0));
    check("m1_dv",    32'(o_m1_DV), 32'(dlv && g_who == 1));
    check("m0_to",    32'(o_m0_timeout), 32'(dlv && g_who == 0 && g_to));
    check("m1_to",    32'(o_m1_timeout), 32'(dlv && g_who == 1 && g_to));
    check("m0_data",  o_m0_data, e_rdata[0]);
    check("m1_data",  o_m1_data, e_rdata[1]);
    check("perr",     32'(o_protocol_err), 32'(perr));

    if (o_mem_DV) begin
      mem_cnt++; addr_q.push_back(o_mem_address);
      if (first_mem < 0) first_mem = cyc;
      seen_data = o_mem_data; seen_bhw = o_mem_bhw; seen_wnr = o_mem_write_notread;
    end
    if (o_m0_DV) begin
      m0_cnt++;
      if (first_m0 < 0) first_m0 = cyc;
    end
    if (o_m1_DV) m1_cnt++;
    if (o_m0_timeout) to0_cnt++;

    // model update for the edge closing this cycle
    idle_now = !nonidle(cyc);
    infl[0] = !idle_now && g_who == 0;
    infl[1] = !idle_now && g_who == 1;
    if (have_txn && cyc == end_cyc) begin
      e_rdata[g_who] = g_to ? TDATA : r_data;
      $display("txn: m%0d addr=%h wnr=%0b resp=%h timeout=%0b", g_who, e_maddr, e_mwnr,
               e_rdata[g_who], g_to);
    end
    grant_now = 0;
    pick = 0;
    if (idle_now && (s_full[0] || s_full[1])) begin
      pick = (s_full[0] && s_full[1]) ? !last : s_full[1];
      grant_now = 1; last = pick;
      e_mdata = s_data[pick]; e_maddr = s_addr[pick]; e_mbhw = s_bhw[pick]; e_mwnr = s_wnr[pick];
      if (delay_q.size() > 0) d = delay_q.pop_front();
      else begin
        r = int'($urandom_range(0, 15));
        d = (r < 8) ? r % 4 : (r < 12) ? T - 1 + (r - 8) : (r < 14) ? 6 : -1;
      end
      r_data = (rdata_q.size() > 0) ? rdata_q.pop_front() : $urandom;
      have_txn = 1; g_cyc = cyc; g_who = pick;
      if (d >= 0 && d <= T + 1) begin
        r_cyc = cyc + 1 + d; end_cyc = r_cyc; g_to = 0;
      end else begin
        r_cyc = -100; end_cyc = cyc + 2 + T; g_to = 1;
      end
    end
    cap(0, i_m0_DV, i_m0_data, i_m0_address, i_m0_bhw, i_m0_write_notread, infl[0]);
    cap(1, i_m1_DV, i_m1_data, i_m1_address, i_m1_bhw, i_m1_write_notread, infl[1]);
    if (grant_now) s_full[pick] = 0;

    @(posedge clk);
    #1;
    cyc++;
    i_m0_DV = 0; i_m1_DV = 0; force_mem = 0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    i_reset = 1; i_m0_DV = 0; i_m1_DV = 0; i_mem_DV = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_mem_dv", 32'(o_mem_DV), 32'd0);
    check("rst_mem_addr", o_mem_address, 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_m0_dv", 32'(o_m0_DV), 32'd0);
    check("rst_m0_data", o_m0_data, 32'd0);
    check("rst_perr", 32'(o_protocol_err), 32'd0);
    @(posedge clk);
    #1;
    i_reset = 0;
    model_reset();
    clr_ev();
    cyc += 2;
  endtask

  int t0;

  initial begin
    i_reset = 1; i_m0_DV = 0; i_m1_DV = 0; i_mem_DV = 0; i_mem_data = '0;
    i_m0_data = '0; i_m0_address = '0; i_m0_bhw = '0; i_m0_write_notread = 0;
    i_m1_data = '0; i_m1_address = '0; i_m1_bhw = '0; i_m1_write_notread = 0;
    stray_en = 0; force_mem = 0;
    model_reset(); clr_ev();
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // 1: single read, memory answers 3 cycles after o_mem_DV
    delay_q.push_back(3); rdata_q.push_back(32'h12345678);
    t0 = cyc;
    set_req(0, 32'h100, 32'h0, 3'b010, 0);
    ticks(12);
    check("t1_issue_lat", 32'(first_mem - t0), 32'd2);
    check("t1_resp_lat", 32'(first_m0 - first_mem), 32'd4);
    check("t1_m0_data", o_m0_data, 32'h12345678);
    check("t1_m1_cnt", 32'(m1_cnt), 32'd0);

    // 2: simultaneous pair from reset, then M0 alone, then another pair
    do_reset();
    repeat (5) delay_q.push_back(1);
    set_req(0, 32'hA0, 32'h1, 3'b010, 0);
    set_req(1, 32'hB0, 32'h2, 3'b010, 0);
    ticks(12);
    set_req(0, 32'hE0, 32'h3, 3'b010, 0);
    ticks(8);
    set_req(0, 32'hC0, 32'h4, 3'b010, 0);
    set_req(1, 32'hD0, 32'h5, 3'b010, 0);
    ticks(12);
    check("t2_count", 32'(addr_q.size()), 32'd5);
    if (addr_q.size() == 5) begin
      check("t2_first", addr_q[0], 32'hA0);
      check("t2_second", addr_q[1], 32'hB0);
      check("t2_pair2_first", addr_q[3], 32'hD0);
      check("t2_pair2_second", addr_q[4], 32'hC0);
    end

    // 3: M1 write passes through unchanged
    do_reset();
    delay_q.push_back(2);
    set_req(1, 32'h2000, 32'hCAFEF00D, 3'b100, 1);
    ticks(10);
    check("t3_mem_cnt", 32'(mem_cnt), 32'd1);
    check("t3_addr", addr_q.size() > 0 ? addr_q[0] : 32'hX, 32'h2000);
    check("t3_data", seen_data, 32'hCAFEF00D);
    check("t3_bhw", 32'(seen_bhw), 32'd4);
    check("t3_wnr", 32'(seen_wnr), 32'd1);
    check("t3_m1_cnt", 32'(m1_cnt), 32'd1);

    // 4: memory never answers M0; M1 waits in its slot and is served afterwards
    do_reset();
    delay_q.push_back(-1); delay_q.push_back(2);
    set_req(0, 32'h300, 32'h0, 3'b010, 0);
    ticks(4);
    set_req(1, 32'h400, 32'h0, 3'b010, 0);
    ticks(T + 14);
    check("t4_to_lat", 32'(first_m0 - first_mem), 32'(T + 2));
    check("t4_to_cnt", 32'(to0_cnt), 32'd1);
    check("t4_data", o_m0_data, TDATA);
    check("t4_mem_cnt", 32'(mem_cnt), 32'd2);
    check("t4_m1_cnt", 32'(m1_cnt), 32'd1);

    // 5: M0 re-requests while in flight
    do_reset();
    delay_q.push_back(5);
    set_req(0, 32'h500, 32'h0, 3'b010, 0);
    ticks(3);
    set_req(0, 32'h504, 32'h0, 3'b010, 0);
    ticks(12);
    check("t5_perr", 32'(o_protocol_err), 32'd1);
    check("t5_mem_cnt", 32'(mem_cnt), 32'd1);

    // 6: reset during WAIT, then a late memory response
    do_reset();
    delay_q.push_back(-1);
    set_req(0, 32'h600, 32'h0, 3'b010, 0);
    ticks(6);
    check("t6_busy_before", 32'(o_busy), 32'd1);
    do_reset();
    force_mem = 1;
    ticks(4);
    check("t6_m0_cnt", 32'(m0_cnt), 32'd0);
    check("t6_busy", 32'(o_busy), 32'd0);

    // random traffic: well-behaved masters, then unrestricted masters
    stray_en = 1;
    for (int phase = 0; phase < 2; phase++) begin
      do_reset();
      for (int k = 0; k < 700; k++) begin
        for (int n = 0; n < 2; n++)
          if ((phase == 1 || legal(n)) && $urandom_range(0, 4) == 0)
            set_req(n, $urandom, $urandom, 3'($urandom), 1'($urandom));
        tick();
      end
      ticks(T + 10);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
